// File: rtl/video_pkg.sv
// Shared video/frame constants and pixel, coordinate and address types.
package video_pkg;

    localparam int PRECISION  = 11;
    localparam int PIXEL_SIZE = 16;
    localparam int ADDR_WIDTH = 20;
    localparam int H_RES      = 800;
    localparam int V_RES      = 600;

    typedef logic        [PRECISION-1:0]  coord_t;
    typedef logic signed [PRECISION:0]    scoord_t;
    typedef logic        [PIXEL_SIZE-1:0] pixel_t;
    typedef logic        [ADDR_WIDTH-1:0] addr_t;

    // Which write stream wins the next contended cycle.
    typedef enum logic {
        RR_ADC = 1'b0,
        RR_SPI = 1'b1
    } rr_e;

    function automatic scoord_t to_scoord(input coord_t c);
        return scoord_t'({1'b0, c});
    endfunction

endpackage

// File: rtl/pixel_addr_calc.sv
// Maps a signed pixel coordinate to a linear SRAM address (y*H_RES+x) and flags whether it
// lies inside the frame; the address is only meaningful when in_frame is set.
module pixel_addr_calc
    import video_pkg::*;
(
    input  scoord_t x,
    input  scoord_t y,
    output addr_t   addr,
    output logic    in_frame
);

    always_comb begin
        in_frame = (x >= scoord_t'(0)) && (y >= scoord_t'(0)) &&
                   (x < scoord_t'(H_RES)) && (y < scoord_t'(V_RES));
        addr     = addr_t'(y[PRECISION-1:0]) * addr_t'(H_RES) + addr_t'(x[PRECISION-1:0]);
    end

endmodule

// File: rtl/sram_access_arbiter.sv
// Shares the SRAM command port between fg reads, ADC writes and SPI writes with a
// fixed-latency read response pipe. Optional stat counters enabled by SRAM_ARB_STATS_EN.
module sram_access_arbiter
    import video_pkg::*;
#(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 64
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frozen,
    input  logic                  adc_valid,
    input  logic [PRECISION-1:0]  adc_x,
    input  logic [PRECISION-1:0]  adc_y,
    input  logic [PIXEL_SIZE-1:0] adc_data,
    output logic                  adc_ready,
    input  logic                  spi_valid,
    input  logic [PRECISION-1:0]  spi_x,
    input  logic [PRECISION-1:0]  spi_y,
    input  logic [PIXEL_SIZE-1:0] spi_data,
    output logic                  spi_ready,
    input  logic                  rd_req,
    input  logic [PRECISION:0]    rd_x,
    input  logic [PRECISION:0]    rd_y,
    output logic                  rd_resp_valid,
    output logic                  rd_resp_skip,
    output logic [PIXEL_SIZE-1:0] rd_resp_data,
    output logic                  mem_cmd_valid,
    output logic                  mem_cmd_we,
    output logic [ADDR_WIDTH-1:0] mem_cmd_addr,
    output logic [PIXEL_SIZE-1:0] mem_cmd_wdata,
    input  logic [PIXEL_SIZE-1:0] mem_rdata,
    output logic                  starved
`ifdef SRAM_ARB_STATS_EN
    ,
    output logic [31:0]           stat_rd_cnt,
    output logic [31:0]           stat_wr_cnt,
    output logic [31:0]           stat_drop_cnt
`endif
);

    localparam int DEPTH = 1 + MEM_LATENCY;
    localparam int SW    = $clog2(STARVE_LIMIT + 1);

    rr_e             rr_q, rr_nxt;
    addr_t           rd_addr, wr_addr;
    logic            rd_in_frame, wr_in_frame;
    coord_t          wr_x, wr_y;
    pixel_t          wr_data;
    logic            wr_pend, wr_gnt;
    logic            rd_issue, wr_issue;
    logic [DEPTH-1:0] sr_valid, sr_skip;
    logic [SW-1:0]   starve_cnt;

    pixel_addr_calc u_rd_addr (
        .x        (scoord_t'(rd_x)),
        .y        (scoord_t'(rd_y)),
        .addr     (rd_addr),
        .in_frame (rd_in_frame)
    );

    pixel_addr_calc u_wr_addr (
        .x        (to_scoord(wr_x)),
        .y        (to_scoord(wr_y)),
        .addr     (wr_addr),
        .in_frame (wr_in_frame)
    );

    // Reads always win; writes only see the idle cycles, shared round-robin.
    always_comb begin
        adc_ready = 1'b0;
        spi_ready = 1'b0;
        rr_nxt    = rr_q;
        if (!rd_req) begin
            if (adc_valid && spi_valid) begin
                if (rr_q == RR_ADC) begin
                    adc_ready = 1'b1;
                    rr_nxt    = RR_SPI;
                end else begin
                    spi_ready = 1'b1;
                    rr_nxt    = RR_ADC;
                end
            end else if (adc_valid) begin
                adc_ready = 1'b1;
            end else if (spi_valid) begin
                spi_ready = 1'b1;
            end
        end
    end

    always_comb begin
        wr_x     = spi_ready ? spi_x    : adc_x;
        wr_y     = spi_ready ? spi_y    : adc_y;
        wr_data  = spi_ready ? spi_data : adc_data;
        wr_pend  = adc_valid | spi_valid;
        wr_gnt   = adc_ready | spi_ready;
        rd_issue = rd_req & rd_in_frame;
        wr_issue = wr_in_frame & (spi_ready | (adc_ready & ~frozen));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q          <= RR_ADC;
            mem_cmd_valid <= 1'b0;
            mem_cmd_we    <= 1'b0;
            mem_cmd_addr  <= '0;
            mem_cmd_wdata <= '0;
            sr_valid      <= '0;
            sr_skip       <= '0;
        end else begin
            rr_q          <= rr_nxt;
            mem_cmd_valid <= rd_issue | wr_issue;
            mem_cmd_we    <= wr_issue;
            mem_cmd_addr  <= rd_issue ? rd_addr : (wr_issue ? wr_addr : '0);
            mem_cmd_wdata <= wr_issue ? wr_data : '0;
            sr_valid      <= {sr_valid[DEPTH-2:0], rd_req};
            sr_skip       <= {sr_skip[DEPTH-2:0], rd_req & ~rd_in_frame};
        end
    end

    always_comb begin
        rd_resp_valid = sr_valid[DEPTH-1];
        rd_resp_skip  = sr_valid[DEPTH-1] & sr_skip[DEPTH-1];
        rd_resp_data  = (sr_valid[DEPTH-1] && !sr_skip[DEPTH-1]) ? mem_rdata : '0;
    end

    // Down-counter from STARVE_LIMIT; terminal count latches the sticky flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= SW'(STARVE_LIMIT);
            starved    <= 1'b0;
        end else if (wr_gnt) begin
            starve_cnt <= SW'(STARVE_LIMIT);
        end else if (wr_pend && starve_cnt != '0) begin
            starve_cnt <= starve_cnt - SW'(1);
            if (starve_cnt == SW'(1)) begin
                starved <= 1'b1;
            end
        end
    end

`ifdef SRAM_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_rd_cnt   <= '0;
            stat_wr_cnt   <= '0;
            stat_drop_cnt <= '0;
        end else begin
            if (rd_issue) stat_rd_cnt <= stat_rd_cnt + 32'd1;
            if (wr_issue) stat_wr_cnt <= stat_wr_cnt + 32'd1;
            if ((rd_req && !rd_in_frame) || (wr_gnt && !wr_issue)) begin
                stat_drop_cnt <= stat_drop_cnt + 32'd1;
            end
        end
    end
`else
    // Statistics counters not built in this configuration.
`endif

endmodule
